// File: rtl/matrix_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matrix_pkg : shared constants, types and helpers for matrix_stream_rx  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package matrix_pkg;

  localparam int MATRIX_DIM = 16;
  localparam int WORD_BITS  = 32;
  localparam int LEVEL_W    = 2;
  localparam int PLANES     = 4;

  typedef logic [LEVEL_W-1:0]       level_t;
  typedef level_t [MATRIX_DIM-1:0]  row_levels_t;

  function automatic level_t sat_add(input level_t a, input logic b);
    if (b && (a != level_t'(PLANES - 1)))
      return a + level_t'(1);
    return a;
  endfunction

  // True when exactly one bit of the cathode field is low.
  function automatic logic one_cold(input logic [MATRIX_DIM-1:0] c);
    logic [MATRIX_DIM-1:0] x;
    x = ~c;
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_edge_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | link_edge_sync : multi-flop synchronizer with rising-edge detector     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module link_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/matrix_stream_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matrix_stream_rx : rebuilds the 2-bit 16x16 frame from the 595 link    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module matrix_stream_rx
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         serial_clk,
  input  logic         serial_data,
  input  logic         rclk,
  input  logic         clear,
  input  logic [3:0]   pix_x,
  input  logic [3:0]   pix_y,
  output logic [1:0]   pix_level,
  output logic         frame_done,
  output logic         word_err
);

  localparam int             FILL_W    = $clog2(WORD_BITS + 1);
  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(WORD_BITS);
  localparam int             OCC_W     = $clog2(PLANES);
  localparam logic [OCC_W-1:0]  c_OCC_LAST  = OCC_W'(PLANES - 1);
  localparam logic [3:0]     c_LAST_ROW = 4'(MATRIX_DIM - 1);

  logic w_sclk_level, w_sclk_rise;
  logic w_data_level, w_data_rise;
  logic w_rclk_level, w_rclk_rise;
  logic w_clear_level, w_clear_rise;
  logic w_unused;

  link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(serial_clk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise));

  link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .i_async(serial_data),
    .o_level(w_data_level), .o_rise(w_data_rise));

  link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk(clk), .rst_n(rst_n), .i_async(rclk),
    .o_level(w_rclk_level), .o_rise(w_rclk_rise));

  link_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
    .clk(clk), .rst_n(rst_n), .i_async(clear),
    .o_level(w_clear_level), .o_rise(w_clear_rise));

  assign w_unused = &{1'b0, w_sclk_level, w_data_rise, w_rclk_level, w_clear_rise};

  logic [WORD_BITS-1:0] r_shift;
  logic [FILL_W-1:0]    r_fill;
  logic [WORD_BITS-1:0] r_storage;
  logic                 r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (!w_clear_level) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (w_sclk_rise) begin
      r_shift <= {r_shift[WORD_BITS-2:0], w_data_level};
      if (r_fill != c_FILL_FULL)
        r_fill <= r_fill + 1'b1;
    end
  end

  // r_shift still holds the pre-shift word if a shift lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_storage <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= 1'b0;
      if (w_rclk_rise) begin
        r_storage <= r_shift;
        r_pending <= (r_fill == c_FILL_FULL);
      end
    end
  end

  logic [MATRIX_DIM-1:0] w_anode;
  logic [MATRIX_DIM-1:0] w_cathode;
  logic                  w_valid;
  logic [3:0]            w_row;
  row_levels_t           w_sum;

  assign w_anode   = r_storage[WORD_BITS-1:MATRIX_DIM];
  assign w_cathode = r_storage[MATRIX_DIM-1:0];
  assign w_valid   = one_cold(w_cathode);

  always_comb begin
    w_row = '0;
    for (int p = 0; p < MATRIX_DIM; p++) begin
      if (!w_cathode[p])
        w_row = 4'(MATRIX_DIM - 1 - p);
    end
  end

  row_levels_t           r_acc [MATRIX_DIM];
  logic [OCC_W-1:0]      r_occ [MATRIX_DIM];
  row_levels_t           r_fb  [MATRIX_DIM];
  logic                  r_frame_done;
  logic                  r_word_err;

  generate
    for (genvar gi = 0; gi < MATRIX_DIM; gi++) begin : g_sum
      assign w_sum[gi] = sat_add(r_acc[w_row][gi], w_anode[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MATRIX_DIM; r++) begin
        r_acc[r] <= '0;
        r_occ[r] <= '0;
        r_fb[r]  <= '0;
      end
      r_frame_done <= 1'b0;
      r_word_err   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_word_err   <= 1'b0;
      if (r_pending) begin
        if (!w_valid) begin
          r_word_err <= 1'b1;
        end else if (r_occ[w_row] == c_OCC_LAST) begin
          r_fb[w_row]  <= w_sum;
          r_acc[w_row] <= '0;
          r_occ[w_row] <= '0;
          r_frame_done <= (w_row == c_LAST_ROW);
        end else begin
          r_acc[w_row] <= w_sum;
          r_occ[w_row] <= r_occ[w_row] + 1'b1;
        end
      end
    end
  end

  logic [1:0] r_pix_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pix_level <= '0;
    else
      r_pix_level <= r_fb[pix_y][pix_x];
  end

  assign pix_level  = r_pix_level;
  assign frame_done = r_frame_done;
  assign word_err   = r_word_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_matrix_stream_rx : randomized link stimulus with scoreboard checks  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_matrix_stream_rx;
  import matrix_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int H           = 4;   // clk cycles per link half-period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_clk = 1'b0;
  logic       serial_data = 1'b0;
  logic       rclk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] pix_x = '0;
  logic [3:0] pix_y = '0;
  logic [1:0] pix_level;
  logic       frame_done;
  logic       word_err;

  matrix_stream_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .serial_clk(serial_clk), .serial_data(serial_data),
    .rclk(rclk), .clear(clear), .pix_x(pix_x), .pix_y(pix_y),
    .pix_level(pix_level), .frame_done(frame_done), .word_err(word_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { bit is_frame; int at; } ev_t;
  ev_t exp_q[$];

  // Reference model: per-row plane counts and saturating sums.
  int m_acc [16][16];
  int m_occ [16];
  int m_fb  [16][16];
  int m_fill;
  int lv    [16][16];

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (frame_done || word_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event frame_done=%0d word_err=%0d cycle=%0d required none",
                 frame_done, word_err, cyc);
      end else begin
        e = exp_q.pop_front();
        if (frame_done !== e.is_frame || word_err !== !e.is_frame || cyc != e.at) begin
          failures++;
          $display("FAIL event got frame_done=%0d word_err=%0d at cycle %0d required frame_done=%0d word_err=%0d at cycle %0d",
                   frame_done, word_err, cyc, e.is_frame, !e.is_frame, e.at);
        end
      end
    end
  end

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_occ[r] = 0;
      for (int i = 0; i < 16; i++) begin
        m_acc[r][i] = 0;
        m_fb[r][i]  = 0;
      end
    end
    m_fill = 0;
  endtask

  task automatic model_word(input logic [31:0] w, input int at);
    int zeros, p, r, s;
    ev_t e;
    zeros = 0;
    p = 0;
    for (int b = 0; b < 16; b++)
      if (!w[b]) begin zeros++; p = b; end
    if (zeros != 1) begin
      e.is_frame = 1'b0; e.at = at + SYNC_STAGES + 2;
      exp_q.push_back(e);
      return;
    end
    r = 15 - p;
    for (int i = 0; i < 16; i++) begin
      s = m_acc[r][i] + int'(w[16+i]);
      m_acc[r][i] = (s > 3) ? 3 : s;
    end
    m_occ[r]++;
    if (m_occ[r] == 4) begin
      for (int i = 0; i < 16; i++) begin
        m_fb[r][i]  = m_acc[r][i];
        m_acc[r][i] = 0;
      end
      m_occ[r] = 0;
      if (r == 15) begin
        e.is_frame = 1'b1; e.at = at + SYNC_STAGES + 2;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    serial_data = b;
    wait_cyc(H);
    serial_clk = 1'b1;
    if (clear) m_fill = (m_fill < 32) ? m_fill + 1 : 32;
    wait_cyc(H);
    serial_clk = 1'b0;
  endtask

  task automatic pulse_rclk(input logic [31:0] w);
    int at;
    wait_cyc(H);
    rclk = 1'b1;
    at = cyc;
    if (m_fill == 32) model_word(w, at);
    wait_cyc(H);
    rclk = 1'b0;
    wait_cyc(H);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 31; b >= 0; b--) shift_bit(w[b]);
    pulse_rclk(w);
  endtask

  function automatic logic [31:0] row_word(input int r, input int p);
    logic [15:0] an;
    logic [15:0] one;
    for (int i = 0; i < 16; i++) an[i] = (lv[r][i] > p);
    one = 16'd1;
    return {an, ~(one << (15 - r))};
  endfunction

  task automatic randomize_levels();
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++)
        lv[r][i] = $urandom_range(0, 3);
  endtask

  task automatic send_rows(input int n);
    int order[64];
    int j, t;
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < n; i++) send_word(row_word(order[i] / 4, order[i] % 4));
  endtask

  task automatic check_fb(input string tag);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        pix_y = 4'(y);
        pix_x = 4'(x);
        @(negedge clk);
        checks++;
        if (pix_level !== 2'(m_fb[y][x])) begin
          failures++;
          $display("FAIL %s pix(%0d,%0d) got %0d required %0d", tag, y, x, pix_level, m_fb[y][x]);
        end
      end
  endtask

  task automatic drain(input string tag);
    wait_cyc(12);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_events got %0d outstanding required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [15:0] cath;
    logic [15:0] one;
    logic [15:0] errs [3];
    errs[0] = 16'h0000; errs[1] = 16'hFFFF; errs[2] = 16'h7FFE;
    one = 16'd1;

    model_reset();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8);

    check_fb("reset");
    drain("reset");

    cath = ~(one << 8);
    w = {16'h8888, cath};
    repeat (4) send_word(w);
    drain("row7");
    check_fb("row7");

    randomize_levels();
    send_rows(64);
    drain("frame");
    check_fb("frame");

    randomize_levels();
    send_word(row_word(5, 0));
    send_word(row_word(5, 1));
    for (int k = 0; k < 3; k++) send_word({16'($urandom), errs[k]});
    send_word(row_word(5, 2));
    send_word(row_word(5, 3));
    drain("bad_cathode");
    check_fb("bad_cathode");

    for (int b = 31; b >= 16; b--) shift_bit(1'($urandom));
    clear = 1'b0;
    m_fill = 0;
    wait_cyc(2 * H);
    clear = 1'b1;
    wait_cyc(2 * H);
    for (int b = 15; b >= 0; b--) shift_bit(row_word(3, 0) >> b);
    pulse_rclk(row_word(3, 0));
    drain("clear_drop");
    check_fb("clear_drop");

    do_reset();
    w = row_word(0, 0);
    for (int b = 19; b >= 0; b--) shift_bit(w[b]);
    pulse_rclk(w);
    drain("short_drop");
    check_fb("short_drop");

    randomize_levels();
    send_rows(32);
    do_reset();
    send_rows(64);
    drain("resend");
    check_fb("resend");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_stream_rx.md
# matrix_stream_rx

Receiving end of the 16x16 LED-matrix serial link: samples the `serial_clk`/`serial_data`/`rclk`/`clear` stream that the matrix frame-buffer driver emits toward the 74HC595 chain and rebuilds the 2-bit-per-pixel frame it encodes. Used as a loopback monitor in the Pmod_Matrix256 designs and as the input stage of a daisy-chained second matrix board. Each row is sent once per brightness plane; the block counts lit planes per pixel and exposes the resulting frame through a registered read port.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for the four link inputs (≥2).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `serial_clk` in 1: link shift clock, asynchronous to `clk`.
- `serial_data` in 1: link data, sampled on `serial_clk` rise.
- `rclk` in 1: link storage latch, acts on rise.
- `clear` in 1: active-low shift-register clear.
- `pix_x` in 4: read column, 0..15.
- `pix_y` in 4: read row, 0..15.
- `pix_level` out 2: brightness at (`pix_y`,`pix_x`), registered.
- `frame_done` out 1: one-cycle pulse when row 15 commits.
- `word_err` out 1: one-cycle pulse when a latched word has an invalid cathode field.

## Operation
- All four link inputs pass through SYNC_STAGES flops; rise detection uses one further flop. Link high/low phases are ≥ SYNC_STAGES+2 `clk` cycles (the driver gives ≥100).
- Synced `clear` low: shift register and fill counter go to 0. Takes priority over shifting.
- `serial_clk` rise: shift_reg <= {shift_reg[30:0], serial_data}. The first bit of a word ends in bit 31. Fill counter increments and saturates at 32.
- `rclk` rise: storage <= shift_reg, using the pre-shift value if a `serial_clk` rise is detected in the same cycle. The word is marked pending only if fill = 32; otherwise it is dropped silently with no error.
- Decode of a pending word:
  - anode[i] = storage[16+i], where i is the pixel column.
  - cathode = storage[15:0].
  - The word is valid iff exactly one cathode bit is 0, at position p; row r = 15−p.
  - Any other cathode pattern pulses `word_err` and changes no state.
- Valid word for row r:
  - acc[r][i] <= min(acc[r][i] + anode[i], 3).
  - occ[r] increments.
  - If occ[r] was 3 (fourth occurrence), commit: fb[r][i] <= min(acc[r][i] + anode[i], 3), then acc[r] <= 0 and occ[r] <= 0. Pulse `frame_done` if r = 15.
- Rows may arrive in any order. Interleaving between rows is allowed; each row accumulates independently.
- Read port: `pix_level` <= fb[pix_y][pix_x] every cycle. A read of the row being committed in that same cycle returns the old value.

## Timing
- Reset values: shift_reg, storage, fill, acc, occ, and fb are all 0. `pix_level`, `frame_done`, and `word_err` are 0.
- Input-to-detect latency: SYNC_STAGES+1 cycles after a link edge.
- rclk rise detected in cycle T:
  - storage is loaded at the end of T.
  - acc/occ/fb are updated at the end of T+1.
  - `frame_done` or `word_err` is high during T+2.
  - The new fb value is readable on `pix_level` at T+3 if `pix_x`/`pix_y` are presented at T+2.
- Back-to-back rclk rises are at least one link period apart, so the pipeline never overlaps.
- Reset asserted mid-word or mid-frame: all state clears immediately. The first word after release needs 32 fresh shifts before it is accepted.

## Structure
- Package `matrix_pkg` holds:
  - MATRIX_DIM = 16
  - WORD_BITS = 32
  - LEVEL_W = 2
  - PLANES = 4
  - typedef `level_t` (logic [1:0])
  - typedef `row_levels_t` (level_t [15:0])
- Sub-module `link_edge_sync` (SYNC_STAGES synchronizer plus rise detector, outputs level and rise pulse), instantiated once per link input.
- Datapath (shift/storage/decode/accumulate/commit) lives in the top module.

## Test plan
- Reset, then read all 256 pixels -> every `pix_level` = 0; `frame_done` and `word_err` never pulse.
- Send 4 words for row 7 with anode 0x8888 in all planes -> after the 4th, pix (7,15) = 3, (7,3) = 3, (7,0) = 0; no `frame_done`.
- Full 64-word frame (16 rows × 4 planes) encoding levels with pixel level L lit in planes p < L -> all 256 `pix_level` match the source; exactly one `frame_done`, 2 cycles after the last rclk detect.
- Cathode field 0x0000, then 0xFFFF, then 0x7FFE -> three `word_err` pulses; acc, occ, and fb are unchanged.
- rclk rise after only 20 shifts following reset, or `clear` held low mid-word -> word dropped, no `word_err`, fb unchanged.
- Assert `rst_n` low midway through a frame, then resend the full frame -> fb matches only the resent frame; no partial accumulation carries over.
